// File: rtl/mc_seq_pkg.sv
// Shared types for the 1-bit ICU program sequencer.
//   seq_state_t   : sequencer control state
//   fault_t       : latched fault cause reported on fault_code
//   instruction_t : 4-bit ICU opcode driven on the instruction bus
package mc_seq_pkg;

    localparam int unsigned OPC_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        FLT_NONE = 2'd0,
        FLT_OVF  = 2'd1,
        FLT_UNF  = 2'd2,
        FLT_WDOG = 2'd3
    } fault_t;

    typedef enum logic [OPC_W-1:0] {
        OP_NOPO = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } instruction_t;

endpackage

// File: rtl/mc_ret_stack.sv
// Hardware return-address LIFO for subroutine calls.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears sp only)
//   push, pop  : one operation per cycle; caller guarantees !full / !empty
//   din        : address pushed
//   dout       : current top of stack (valid when !empty)
//   sp         : occupancy 0..DEPTH
//   full/empty : occupancy flags
module mc_ret_stack #(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned SP_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_top_idx;

    assign w_wr_idx  = IDX_W'(r_sp);
    assign w_top_idx = IDX_W'(r_sp - SP_W'(1));

    // Entries are deliberately not reset; only the pointer is.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    assign dout  = r_mem[w_top_idx];
    assign sp    = r_sp;
    assign full  = (r_sp == SP_W'(DEPTH));
    assign empty = (r_sp == '0);

endmodule

// File: rtl/mc_sequencer.sv
// Program sequencer for the 1-bit ICU: owns the PC, fetches {opcode, operand}
// words from a combinational ROM, and handles JMP, call/return via a hardware
// return stack, and halt/resume.
// Optional feature: define MC_SEQ_WDOG_EN to add a watchdog that faults after
// WDOG_CYCLES RUN cycles without a NOPO.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, resume       : leave IDLE (PC=0) / leave HALT (PC+1)
//   prog_addr/prog_data : ROM address (=PC) and returned word
//   instruction,io_addr : opcode and operand to the ICU (NOPO/0 when not running)
//   icu_rst             : ICU reset, high in IDLE and FAULT
//   jmp,rtn,flag_o,flag_f : ICU outputs, sampled on posedge while running
//   halted, fault       : state decodes
//   fault_code          : 0 none, 1 overflow, 2 underflow, 3 watchdog
//   sp                  : return-stack occupancy
module mc_sequencer
    import mc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               resume,
    output logic [ADDR_W-1:0]                  prog_addr,
    input  logic [OPC_W+ADDR_W-1:0]            prog_data,
    output instruction_t                       instruction,
    output logic [ADDR_W-1:0]                  io_addr,
    output logic                               icu_rst,
    input  logic                               jmp,
    input  logic                               rtn,
    input  logic                               flag_o,
    input  logic                               flag_f,
    output logic                               halted,
    output logic                               fault,
    output logic [1:0]                         fault_code,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

    if ((STACK_DEPTH == 0) || (WDOG_CYCLES == 0)) begin : g_param_chk
        $error("mc_sequencer: STACK_DEPTH and WDOG_CYCLES must be at least 1");
    end

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_operand;
    fault_t            r_fault_code;
    fault_t            w_fault_nxt;
    logic              r_call_pend;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_top;
    logic              w_full;
    logic              w_empty;
    logic              w_wdog_expire;

    assign w_operand = prog_data[ADDR_W-1:0];
    assign w_pc_inc  = r_pc + ADDR_W'(1);

    mc_ret_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (ADDR_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_top),
        .sp    (sp),
        .full  (w_full),
        .empty (w_empty)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next PC and stack control; flags refer to the word at r_pc
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_nxt = r_fault_code;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = '0;
                end
            end
            RUN: begin
                if (w_wdog_expire) begin
                    w_state_nxt = FAULT;
                    w_fault_nxt = FLT_WDOG;
                end else if (flag_f) begin
                    w_state_nxt = HALT;
                end else if (jmp && r_call_pend) begin
                    if (w_full) begin
                        w_state_nxt = FAULT;
                        w_fault_nxt = FLT_OVF;
                    end else begin
                        w_push   = 1'b1;
                        w_pc_nxt = w_operand;
                    end
                end else if (jmp) begin
                    w_pc_nxt = w_operand;
                end else if (rtn) begin
                    if (w_empty) begin
                        w_state_nxt = FAULT;
                        w_fault_nxt = FLT_UNF;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_top;
                    end
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            HALT: begin
                // The halting NOPF is not re-fetched.
                if (resume) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = w_pc_inc;
                end
            end
            FAULT: begin
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        icu_rst     = 1'b1;
        instruction = OP_NOPO;
        io_addr     = '0;
        halted      = 1'b0;
        fault       = 1'b0;
        case (r_state)
            RUN: begin
                icu_rst     = 1'b0;
                instruction = instruction_t'(prog_data[ADDR_W +: OPC_W]);
                io_addr     = w_operand;
            end
            HALT: begin
                icu_rst = 1'b0;
                halted  = 1'b1;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // PC, fault cause and call-pending flag (a NOPO directly before JMP marks a call)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= '0;
            r_fault_code <= FLT_NONE;
            r_call_pend  <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_fault_code <= w_fault_nxt;
            r_call_pend  <= (r_state == RUN) ? flag_o : 1'b0;
        end
    end

`ifdef MC_SEQ_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] r_wdog;

    // Reload on RUN entry and on every NOPO; count down otherwise while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= WD_W'(WDOG_CYCLES);
        end else if ((r_state != RUN) && (w_state_nxt == RUN)) begin
            r_wdog <= WD_W'(WDOG_CYCLES);
        end else if (r_state == RUN) begin
            if (flag_o) begin
                r_wdog <= WD_W'(WDOG_CYCLES);
            end else if (r_wdog != '0) begin
                r_wdog <= r_wdog - WD_W'(1);
            end
        end
    end

    assign w_wdog_expire = (r_state == RUN) && !flag_o && (r_wdog == WD_W'(1));
`else
    assign w_wdog_expire = 1'b0;
`endif

    assign prog_addr  = r_pc;
    assign fault_code = r_fault_code;

endmodule

// File: tb/tb_mc_sequencer.sv
// Testbench for mc_sequencer: a behavioural ICU drives the flags, and a
// program-level interpreter predicts PC, stack depth and status every cycle.
module tb_mc_sequencer;
    import mc_seq_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned WDOG  = 8;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;
    localparam int M_FAULT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              resume = 1'b0;
    logic [AW-1:0]     prog_addr;
    logic [AW+3:0]     prog_data;
    instruction_t      instruction;
    logic [AW-1:0]     io_addr;
    logic              icu_rst;
    logic              jmp = 1'b0;
    logic              rtn = 1'b0;
    logic              flag_o = 1'b0;
    logic              flag_f = 1'b0;
    logic              halted;
    logic              fault;
    logic [1:0]        fault_code;
    logic [1:0]        sp;

    logic [AW+3:0]     rom [256];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            m_mode;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk [$];
    bit            m_prev_nopo;
    bit            m_skip;
    logic [1:0]    m_fc;
    int            m_wd;

    mc_sequencer #(
        .ADDR_W      (AW),
        .STACK_DEPTH (DEPTH),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .resume      (resume),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .io_addr     (io_addr),
        .icu_rst     (icu_rst),
        .jmp         (jmp),
        .rtn         (rtn),
        .flag_o      (flag_o),
        .flag_f      (flag_f),
        .halted      (halted),
        .fault       (fault),
        .fault_code  (fault_code),
        .sp          (sp)
    );

    always #5 clk = ~clk;

    assign prog_data = rom[prog_addr];

    // Minimal ICU: latch word on negedge, raise flags, skip the word after RTN
    bit icu_skip = 1'b0;
    always @(negedge clk or posedge icu_rst) begin
        if (icu_rst) begin
            jmp = 1'b0; rtn = 1'b0; flag_o = 1'b0; flag_f = 1'b0; icu_skip = 1'b0;
        end else if (icu_skip) begin
            jmp = 1'b0; rtn = 1'b0; flag_o = 1'b0; flag_f = 1'b0; icu_skip = 1'b0;
        end else begin
            jmp      = (instruction == OP_JMP);
            rtn      = (instruction == OP_RTN);
            flag_o   = (instruction == OP_NOPO);
            flag_f   = (instruction == OP_NOPF);
            icu_skip = (instruction == OP_RTN);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = M_IDLE; m_pc = '0; m_stk.delete();
        m_prev_nopo = 1'b0; m_skip = 1'b0; m_fc = 2'd0; m_wd = WDOG;
    endtask

    task automatic m_fault(input logic [1:0] code);
        m_mode = M_FAULT; m_fc = code;
    endtask

    // One clock of program-level execution
    task automatic m_step(input bit st, input bit rs);
        logic [3:0]    op;
        logic [AW-1:0] arg;
        bit            exec;
        bit            is_nopo;
        case (m_mode)
            M_IDLE: if (st) begin
                m_mode = M_RUN; m_pc = '0; m_prev_nopo = 1'b0; m_skip = 1'b0; m_wd = WDOG;
            end
            M_HALT: if (rs) begin
                m_mode = M_RUN; m_pc = m_pc + 8'd1; m_prev_nopo = 1'b0; m_wd = WDOG;
            end
            M_RUN: begin
                op      = rom[m_pc][AW+3:AW];
                arg     = rom[m_pc][AW-1:0];
                exec    = !m_skip;
                m_skip  = 1'b0;
                is_nopo = exec && (op == 4'(OP_NOPO));
`ifdef MC_SEQ_WDOG_EN
                if (!is_nopo && m_wd == 1) begin
                    m_fault(2'd3);
                    return;
                end
                m_wd = is_nopo ? WDOG : m_wd - 1;
`endif
                if (!exec) begin
                    m_pc = m_pc + 8'd1;
                end else if (op == 4'(OP_NOPF)) begin
                    m_mode = M_HALT;
                end else if (op == 4'(OP_JMP)) begin
                    if (m_prev_nopo) begin
                        if (m_stk.size() == DEPTH) m_fault(2'd1);
                        else begin m_stk.push_back(m_pc + 8'd1); m_pc = arg; end
                    end else begin
                        m_pc = arg;
                    end
                end else if (op == 4'(OP_RTN)) begin
                    if (m_stk.size() == 0) m_fault(2'd2);
                    else begin m_pc = m_stk.pop_back(); m_skip = 1'b1; end
                end else begin
                    m_pc = m_pc + 8'd1;
                end
                m_prev_nopo = is_nopo;
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        logic [3:0]    e_op;
        logic [AW-1:0] e_io;
        e_op = (m_mode == M_RUN) ? rom[m_pc][AW+3:AW] : 4'(OP_NOPO);
        e_io = (m_mode == M_RUN) ? rom[m_pc][AW-1:0] : '0;
        chk({tag, ".pc"},      32'(prog_addr),   32'(m_pc));
        chk({tag, ".sp"},      32'(sp),          32'(m_stk.size()));
        chk({tag, ".halted"},  32'(halted),      32'(m_mode == M_HALT));
        chk({tag, ".fault"},   32'(fault),       32'(m_mode == M_FAULT));
        chk({tag, ".fcode"},   32'(fault_code),  32'(m_fc));
        chk({tag, ".icu_rst"}, 32'(icu_rst),     32'(m_mode == M_IDLE || m_mode == M_FAULT));
        chk({tag, ".instr"},   32'(instruction), 32'(e_op));
        chk({tag, ".io"},      32'(io_addr),     32'(e_io));
    endtask

    task automatic step(input string tag, input bit st, input bit rs);
        start = st; resume = rs;
        m_step(st, rs);
        @(posedge clk); #1;
        start = 1'b0; resume = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; resume = 1'b0;
        m_reset();
        #1;
        check_all("rst_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all("rst");
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = {4'(OP_LD), 8'h00};
    endtask

    task automatic set_w(input int a, input instruction_t op, input logic [7:0] arg);
        rom[a] = {4'(op), arg};
    endtask

    function automatic logic [AW+3:0] rand_word();
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 15);
        if (r < 3)       op = 4'(OP_NOPO);
        else if (r < 5)  op = 4'(OP_JMP);
        else if (r == 5) op = 4'(OP_RTN);
        else if (r == 6) op = 4'(OP_NOPF);
        else             op = 4'($urandom_range(1, 11));
        return {op, 8'($urandom_range(0, 255))};
    endfunction

    initial begin
        // Straight-line program halts on NOPF, start/resume filtering
        clear_rom();
        set_w(0, OP_LD, 8'h01); set_w(1, OP_OR, 8'h02); set_w(2, OP_STO, 8'h03); set_w(3, OP_NOPF, 8'h00);
        do_reset();
        chk("t1.reset_pc", 32'(prog_addr), 32'd0);
        step("t1.idle", 1'b0, 1'b1);
        step("t1.start", 1'b1, 1'b0);
        chk("t1.pc0", 32'(prog_addr), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step("t1.run", 1'b0, 1'b0);
            chk("t1.pc_seq", 32'(prog_addr), 32'(i));
        end
        step("t1.halt", 1'b1, 1'b0);
        chk("t1.halted", 32'(halted), 32'd1);
        chk("t1.halt_pc", 32'(prog_addr), 32'd3);
        step("t1.hold", 1'b1, 1'b0);
        step("t1.resume", 1'b0, 1'b1);
        chk("t1.resume_pc", 32'(prog_addr), 32'd4);

        // Plain jump
        clear_rom();
        set_w(5, OP_JMP, 8'h20); set_w(8'h20, OP_NOPF, 8'h00);
        do_reset();
        step("t2.start", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("t2.run", 1'b0, 1'b0);
        step("t2.jmp", 1'b0, 1'b0);
        chk("t2.jmp_pc", 32'(prog_addr), 32'h20);
        chk("t2.jmp_sp", 32'(sp), 32'd0);

        // Call and return; word 6 is skipped by the ICU
        clear_rom();
        set_w(4, OP_NOPO, 8'h00); set_w(5, OP_JMP, 8'h40); set_w(8'h40, OP_RTN, 8'h00);
        set_w(7, OP_NOPF, 8'h00);
        do_reset();
        step("t3.start", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("t3.run", 1'b0, 1'b0);
        step("t3.call", 1'b0, 1'b0);
        chk("t3.call_pc", 32'(prog_addr), 32'h40);
        chk("t3.call_sp", 32'(sp), 32'd1);
        step("t3.ret", 1'b0, 1'b0);
        chk("t3.ret_pc", 32'(prog_addr), 32'd6);
        chk("t3.ret_sp", 32'(sp), 32'd0);
        step("t3.skip", 1'b0, 1'b0);
        step("t3.halt", 1'b0, 1'b0);
        chk("t3.halted", 32'(halted), 32'd1);

        // Nested calls overflow a 2-deep stack
        clear_rom();
        set_w(0, OP_NOPO, 8'h00); set_w(1, OP_JMP, 8'h10);
        set_w(8'h10, OP_NOPO, 8'h00); set_w(8'h11, OP_JMP, 8'h20);
        set_w(8'h20, OP_NOPO, 8'h00); set_w(8'h21, OP_JMP, 8'h30);
        do_reset();
        step("t4.start", 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step("t4.run", 1'b0, 1'b0);
        chk("t4.fault", 32'(fault), 32'd1);
        chk("t4.fcode", 32'(fault_code), 32'd1);
        chk("t4.icu_rst", 32'(icu_rst), 32'd1);
        chk("t4.pc_hold", 32'(prog_addr), 32'h21);
        step("t4.stuck", 1'b1, 1'b1);

        // Return with an empty stack
        clear_rom();
        set_w(0, OP_RTN, 8'h00);
        do_reset();
        step("t4u.start", 1'b1, 1'b0);
        step("t4u.rtn", 1'b0, 1'b0);
        chk("t4u.fcode", 32'(fault_code), 32'd2);

        // Asynchronous reset in the middle of a subroutine
        clear_rom();
        set_w(0, OP_NOPO, 8'h00); set_w(1, OP_JMP, 8'h10);
        do_reset();
        step("t5.start", 1'b1, 1'b0);
        step("t5.run", 1'b0, 1'b0);
        step("t5.call", 1'b0, 1'b0);
        step("t5.sub", 1'b0, 1'b0);
        chk("t5.sp_before", 32'(sp), 32'd1);
        rst_n = 1'b0;
        m_reset();
        #2;
        chk("t5.async_pc", 32'(prog_addr), 32'd0);
        chk("t5.async_sp", 32'(sp), 32'd0);
        chk("t5.async_icu_rst", 32'(icu_rst), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("t5.restart", 1'b1, 1'b0);
        chk("t5.restart_pc", 32'(prog_addr), 32'd0);
        step("t5.again", 1'b0, 1'b0);

        // PC wraps from the top of the address space
        clear_rom();
        set_w(0, OP_JMP, 8'hFE);
        do_reset();
        step("wrap.start", 1'b1, 1'b0);
        step("wrap.jmp", 1'b0, 1'b0);
        step("wrap.fe", 1'b0, 1'b0);
        step("wrap.ff", 1'b0, 1'b0);
        chk("wrap.pc0", 32'(prog_addr), 32'd0);

`ifdef MC_SEQ_WDOG_EN
        // Tight loop without NOPO trips the watchdog on the 8th cycle
        clear_rom();
        set_w(0, OP_JMP, 8'h00);
        do_reset();
        step("wd.start", 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step("wd.loop", 1'b0, 1'b0);
        chk("wd.alive", 32'(fault), 32'd0);
        step("wd.trip", 1'b0, 1'b0);
        chk("wd.fcode", 32'(fault_code), 32'd3);

        clear_rom();
        set_w(0, OP_NOPO, 8'h00); set_w(1, OP_LD, 8'h00); set_w(2, OP_JMP, 8'h00);
        do_reset();
        step("wdk.start", 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step("wdk.loop", 1'b0, 1'b0);
        chk("wdk.nofault", 32'(fault), 32'd0);
`endif

        // Random programs with random start/resume pulses
        for (int p = 0; p < 16; p++) begin
            for (int a = 0; a < 256; a++) rom[a] = rand_word();
            do_reset();
            for (int c = 0; c < 250; c++) begin
                if (m_mode == M_FAULT && $urandom_range(0, 3) == 0) do_reset();
                step("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
